// File: rtl/dual_issue_hazard_unit.sv
// Hazard and dependency controller for a dual-issue pipeline.
// Detects intra-pair RAW/WAW dependencies, a slot-1 control dependency and
// load-use hazards, and drives stall/flush controls for fetch, decode and execute.
module dual_issue_hazard_unit #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned CHECK_WAW  = 1,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidD1,
    input  logic             ValidD2,
    input  logic [REG_W-1:0] RdD1,
    input  logic [REG_W-1:0] RdD2,
    input  logic [REG_W-1:0] Rs1D1,
    input  logic [REG_W-1:0] Rs2D1,
    input  logic [REG_W-1:0] Rs1D2,
    input  logic [REG_W-1:0] Rs2D2,
    input  logic             RegWriteD1,
    input  logic             RegWriteD2,
    input  logic             BranchD1,
    input  logic [REG_W-1:0] RdE1,
    input  logic [REG_W-1:0] RdE2,
    input  logic             MemReadE1,
    input  logic             MemReadE2,
    input  logic             FlushIn,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE1,
    output logic             FlushE2,
    output logic [CNT_W-1:0] SplitCount
);

    localparam int unsigned LCNT_W = 3;

    typedef enum logic [1:0] {
        PAIR      = 2'd0,
        LOAD_WAIT = 2'd1,
        SPLIT     = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LCNT_W-1:0] lcnt;
    logic [LCNT_W-1:0] lcnt_nxt;
    logic              split_inc;

    logic              lu_s1;
    logic              lu_s2;
    logic              lu;
    logic              dep;
    logic              ctl;

    // Load in execute whose non-zero destination matches a decode source
    function automatic logic ld_hit(input logic mr, input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
        return mr && (rd != '0) && (rd == rs);
    endfunction

    // Hazard detection for the current decode pair
    always_comb begin
        lu_s1 = ValidD1 && (ld_hit(MemReadE1, RdE1, Rs1D1) || ld_hit(MemReadE1, RdE1, Rs2D1) ||
                            ld_hit(MemReadE2, RdE2, Rs1D1) || ld_hit(MemReadE2, RdE2, Rs2D1));
        lu_s2 = ValidD2 && (ld_hit(MemReadE1, RdE1, Rs1D2) || ld_hit(MemReadE1, RdE1, Rs2D2) ||
                            ld_hit(MemReadE2, RdE2, Rs1D2) || ld_hit(MemReadE2, RdE2, Rs2D2));
        lu    = lu_s1 || lu_s2;
        dep   = ValidD1 && ValidD2 && RegWriteD1 && (RdD1 != '0) &&
                ((RdD1 == Rs1D2) || (RdD1 == Rs2D2) ||
                 ((CHECK_WAW != 0) && RegWriteD2 && (RdD1 == RdD2)));
        ctl   = ValidD1 && ValidD2 && BranchD1;
    end

    // Next-state and stall/flush decode; redirect and reset override everything
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        split_inc = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushE1   = 1'b0;
        FlushE2   = 1'b0;
        if (rst || FlushIn) begin
            state_nxt = PAIR;
            lcnt_nxt  = '0;
        end else begin
            case (state)
                PAIR: begin
                    if (lu) begin
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        FlushE1  = 1'b1;
                        FlushE2  = 1'b1;
                        lcnt_nxt = LCNT_W'(LOAD_STALL - 1);
                        if (LOAD_STALL > 1) state_nxt = LOAD_WAIT;
                    end else if (dep || ctl) begin
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        FlushE2   = 1'b1;
                        state_nxt = SPLIT;
                        split_inc = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    FlushE1 = 1'b1;
                    FlushE2 = 1'b1;
                    if (lcnt <= LCNT_W'(1)) begin
                        lcnt_nxt  = '0;
                        state_nxt = PAIR;
                    end else begin
                        lcnt_nxt = lcnt - LCNT_W'(1);
                    end
                end
                SPLIT: begin
                    // Slot 1 already issued; only slot 2 goes down this cycle
                    FlushE1 = 1'b1;
                    if (lu_s2) begin
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        FlushE2 = 1'b1;
                    end else begin
                        state_nxt = PAIR;
                    end
                end
                default: state_nxt = PAIR;
            endcase
        end
    end

    // State, load-stall counter and saturating split counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PAIR;
            lcnt       <= '0;
            SplitCount <= '0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
            if (split_inc && (SplitCount != '1)) SplitCount <= SplitCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dual_issue_hazard_unit.sv
// Directed bench for dual_issue_hazard_unit: a WAW-checking instance with a
// 3-cycle load stall and a non-WAW instance with a 2-bit split counter.
module tb_dual_issue_hazard_unit;

    logic       clk;
    logic       rst;
    logic       ValidD1, ValidD2;
    logic [4:0] RdD1, RdD2, Rs1D1, Rs2D1, Rs1D2, Rs2D2;
    logic       RegWriteD1, RegWriteD2, BranchD1;
    logic [4:0] RdE1, RdE2;
    logic       MemReadE1, MemReadE2;
    logic       FlushIn;

    logic        StallF, StallD, FlushE1, FlushE2;
    logic [15:0] SplitCount;
    logic        StallF2, StallD2, FlushE12, FlushE22;
    logic [1:0]  SplitCount2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       v1, v2;
        logic [4:0] rd1, rd2, rs11, rs21, rs12, rs22;
        logic       rw1, rw2, br;
        logic [4:0] rde1, rde2;
        logic       mr1, mr2;
        logic [3:0] exp_w;
        logic [3:0] exp_nw;
    } vec_t;

    // Output encoding: {StallF, StallD, FlushE1, FlushE2}
    localparam logic [3:0] O_NONE = 4'b0000;
    localparam logic [3:0] O_DEP  = 4'b1101;
    localparam logic [3:0] O_LU   = 4'b1111;
    localparam logic [3:0] O_S2   = 4'b0010;

    dual_issue_hazard_unit #(.REG_W(5), .CHECK_WAW(1), .LOAD_STALL(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ValidD1(ValidD1), .ValidD2(ValidD2),
        .RdD1(RdD1), .RdD2(RdD2), .Rs1D1(Rs1D1), .Rs2D1(Rs2D1), .Rs1D2(Rs1D2), .Rs2D2(Rs2D2),
        .RegWriteD1(RegWriteD1), .RegWriteD2(RegWriteD2), .BranchD1(BranchD1),
        .RdE1(RdE1), .RdE2(RdE2), .MemReadE1(MemReadE1), .MemReadE2(MemReadE2),
        .FlushIn(FlushIn), .StallF(StallF), .StallD(StallD), .FlushE1(FlushE1),
        .FlushE2(FlushE2), .SplitCount(SplitCount)
    );

    dual_issue_hazard_unit #(.REG_W(5), .CHECK_WAW(0), .LOAD_STALL(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ValidD1(ValidD1), .ValidD2(ValidD2),
        .RdD1(RdD1), .RdD2(RdD2), .Rs1D1(Rs1D1), .Rs2D1(Rs2D1), .Rs1D2(Rs1D2), .Rs2D2(Rs2D2),
        .RegWriteD1(RegWriteD1), .RegWriteD2(RegWriteD2), .BranchD1(BranchD1),
        .RdE1(RdE1), .RdE2(RdE2), .MemReadE1(MemReadE1), .MemReadE2(MemReadE2),
        .FlushIn(FlushIn), .StallF(StallF2), .StallD(StallD2), .FlushE1(FlushE12),
        .FlushE2(FlushE22), .SplitCount(SplitCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent pair: add x5,x1,x2 / add x6,x3,x4
    function automatic vec_t base();
        vec_t v;
        v.v1 = 1'b1; v.v2 = 1'b1;
        v.rd1 = 5'd5; v.rd2 = 5'd6;
        v.rs11 = 5'd1; v.rs21 = 5'd2; v.rs12 = 5'd3; v.rs22 = 5'd4;
        v.rw1 = 1'b1; v.rw2 = 1'b1; v.br = 1'b0;
        v.rde1 = 5'd0; v.rde2 = 5'd0; v.mr1 = 1'b0; v.mr2 = 1'b0;
        v.exp_w = O_NONE; v.exp_nw = O_NONE;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        ValidD1 = v.v1; ValidD2 = v.v2; RdD1 = v.rd1; RdD2 = v.rd2;
        Rs1D1 = v.rs11; Rs2D1 = v.rs21; Rs1D2 = v.rs12; Rs2D2 = v.rs22;
        RegWriteD1 = v.rw1; RegWriteD2 = v.rw2; BranchD1 = v.br;
        RdE1 = v.rde1; RdE2 = v.rde2; MemReadE1 = v.mr1; MemReadE2 = v.mr2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ew, input logic [3:0] enw);
        #1;
        checks++;
        if ({StallF, StallD, FlushE1, FlushE2} !== ew) begin
            errors++;
            $display("FAIL %s waw_unit: got %b required %b", tag,
                     {StallF, StallD, FlushE1, FlushE2}, ew);
        end
        checks++;
        if ({StallF2, StallD2, FlushE12, FlushE22} !== enw) begin
            errors++;
            $display("FAIL %s nowaw_unit: got %b required %b", tag,
                     {StallF2, StallD2, FlushE12, FlushE22}, enw);
        end
    endtask

    task automatic chk_cnt(input string tag, input int unsigned ew, input int unsigned enw);
        checks++;
        if (SplitCount !== 16'(ew)) begin
            errors++;
            $display("FAIL %s SplitCount: got %0d required %0d", tag, SplitCount, ew);
        end
        checks++;
        if (SplitCount2 !== 2'(enw)) begin
            errors++;
            $display("FAIL %s SplitCount2: got %0d required %0d", tag, SplitCount2, enw);
        end
    endtask

    vec_t vt [0:16];
    vec_t v;
    vec_t lu9;

    initial begin
        for (int i = 0; i <= 16; i++) vt[i] = base();
        vt[1].rs12 = 5'd5;                       vt[1].exp_w = O_DEP;  vt[1].exp_nw = O_DEP;
        vt[2].rs22 = 5'd5;                       vt[2].exp_w = O_DEP;  vt[2].exp_nw = O_DEP;
        vt[3].rd2 = 5'd5;                        vt[3].exp_w = O_DEP;
        vt[4].rd2 = 5'd5;  vt[4].rw2 = 1'b0;
        vt[5].rd1 = 5'd0;  vt[5].rs12 = 5'd0;
        vt[6].rw1 = 1'b0;  vt[6].rs12 = 5'd5;
        vt[7].v2 = 1'b0;   vt[7].rs12 = 5'd5;
        vt[8].br = 1'b1;                         vt[8].exp_w = O_DEP;  vt[8].exp_nw = O_DEP;
        vt[9].br = 1'b1;   vt[9].v2 = 1'b0;
        vt[10].mr1 = 1'b1; vt[10].rde1 = 5'd3;   vt[10].exp_w = O_LU;  vt[10].exp_nw = O_LU;
        vt[11].mr2 = 1'b1; vt[11].rde2 = 5'd2;   vt[11].exp_w = O_LU;  vt[11].exp_nw = O_LU;
        vt[12].mr1 = 1'b1; vt[12].rde1 = 5'd0;   vt[12].rs11 = 5'd0;
        vt[13].mr2 = 1'b1; vt[13].rde2 = 5'd3;   vt[13].v2 = 1'b0;
        vt[14].rde1 = 5'd1;
        vt[15].mr1 = 1'b1; vt[15].rde1 = 5'd4;   vt[15].rs12 = 5'd5;
        vt[15].exp_w = O_LU; vt[15].exp_nw = O_LU;
        vt[16].v1 = 1'b0;  vt[16].mr1 = 1'b1;    vt[16].rde1 = 5'd1;

        lu9 = base(); lu9.mr2 = 1'b1; lu9.rde2 = 5'd9; lu9.rs21 = 5'd9;

        rst = 1'b1; FlushIn = 1'b0;
        apply(base());
        chk("reset_outputs", O_NONE, O_NONE);
        step(); step();
        rst = 1'b0;
        chk_cnt("reset_count", 0, 0);

        // Single-cycle decode checks from PAIR; the redirect edge returns to PAIR uncounted
        for (int i = 0; i <= 16; i++) begin
            FlushIn = 1'b0;
            apply(vt[i]);
            chk($sformatf("vec%0d", i), vt[i].exp_w, vt[i].exp_nw);
            FlushIn = 1'b1;
            step();
        end
        FlushIn = 1'b0;
        chk_cnt("table_count", 0, 0);

        // RAW split over two cycles
        v = base(); v.rs12 = 5'd5;
        apply(v);      chk("raw_n", O_DEP, O_DEP);
        step();        chk("raw_n1", O_S2, O_S2);
        apply(base());
        step();        chk("raw_n2", O_NONE, O_NONE);
        chk_cnt("raw_count", 1, 1);

        // Load-use: three stall cycles vs one
        apply(lu9);    chk("lu_c1", O_LU, O_LU);
        step(); apply(base());
        chk("lu_c2", O_LU, O_NONE);
        step();        chk("lu_c3", O_LU, O_NONE);
        step();        chk("lu_c4", O_NONE, O_NONE);

        // Branch split, redirected during the SPLIT cycle
        v = base(); v.br = 1'b1;
        apply(v);      chk("br_n", O_DEP, O_DEP);
        step(); FlushIn = 1'b1;
        chk("br_flush", O_NONE, O_NONE);
        step(); FlushIn = 1'b0;
        chk("br_after_flush", O_DEP, O_DEP);
        FlushIn = 1'b1; step(); FlushIn = 1'b0;
        apply(base());
        chk_cnt("br_count", 2, 2);

        // Load-use during SPLIT: only slot-2 sources stall
        v = base(); v.rs12 = 5'd5;
        apply(v);      chk("sl_n", O_DEP, O_DEP);
        step();
        v.mr1 = 1'b1; v.rde1 = 5'd1;
        apply(v);      chk("sl_lu_slot1", O_S2, O_S2);
        v.rde1 = 5'd4;
        apply(v);      chk("sl_lu_slot2", O_LU, O_LU);
        step(); apply(base());
        chk("sl_held", O_S2, O_S2);
        step();        chk("sl_done", O_NONE, O_NONE);
        chk_cnt("sl_count", 3, 3);

        // Counter saturation on the 2-bit instance
        for (int k = 0; k < 2; k++) begin
            v = base(); v.rs12 = 5'd5;
            apply(v); step(); apply(base()); step();
            chk_cnt($sformatf("sat%0d", k), 4 + k, 3);
        end

        // Reset in the middle of LOAD_WAIT
        apply(lu9); step(); apply(base());
        chk("rst_lw_before", O_LU, O_NONE);
        rst = 1'b1;
        chk("rst_lw_during", O_NONE, O_NONE);
        step(); rst = 1'b0;
        chk("rst_lw_after", O_NONE, O_NONE);
        chk_cnt("rst_count", 0, 0);

        // Redirect in LOAD_WAIT, then a fresh full-length load stall
        apply(lu9);    chk("fl_lw_c1", O_LU, O_LU);
        step(); apply(base()); FlushIn = 1'b1;
        chk("fl_lw_flush", O_NONE, O_NONE);
        step(); FlushIn = 1'b0;
        chk("fl_lw_after", O_NONE, O_NONE);
        apply(lu9);    chk("lu2_c1", O_LU, O_LU);
        step(); apply(base());
        chk("lu2_c2", O_LU, O_NONE);
        step();        chk("lu2_c3", O_LU, O_NONE);
        step();        chk("lu2_c4", O_NONE, O_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_issue_hazard_unit.md
Name: dual_issue_hazard_unit

Overview:
- Hazard and dependency controller for the dual-issue pipeline. Sits beside the two decode stages and drives stall/flush controls for fetch, decode and execute.
- Detects three things: intra-pair data dependencies (slot 2 reads or overwrites slot 1's destination), a slot-1 control dependency (branch/jump in slot 1), and cross-pipeline load-use hazards.
- Intra-pair and control hazards are resolved by splitting the pair over two cycles. Load-use hazards are resolved by a parametrised multi-cycle stall.
- Includes a saturating split counter for performance measurement.

Parameters:
REG_W, 5, register address width
CHECK_WAW, 1, 1 = a same-destination pair (WAW) also forces a split
LOAD_STALL, 1, stall cycles inserted per load-use hazard (1..7)
CNT_W, 16, width of SplitCount

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ValidD1  in  1  decode slot 1 holds a valid instruction
ValidD2  in  1  decode slot 2 holds a valid instruction
RdD1  in  REG_W  slot 1 destination
RdD2  in  REG_W  slot 2 destination
Rs1D1, Rs2D1  in  REG_W  slot 1 sources
Rs1D2, Rs2D2  in  REG_W  slot 2 sources
RegWriteD1, RegWriteD2  in  1  slot writes a register
BranchD1  in  1  slot 1 is a branch or jump
RdE1, RdE2  in  REG_W  execute-stage destinations
MemReadE1, MemReadE2  in  1  execute-stage instruction is a load
FlushIn  in  1  taken branch resolved this cycle (pipeline redirect)
StallF  out  1  hold both fetch PCs
StallD  out  1  hold both decode registers
FlushE1  out  1  insert bubble into execute 1
FlushE2  out  1  insert bubble into execute 2
SplitCount  out  CNT_W  saturating count of split pairs

Behaviour:
- Stall/flush outputs are combinational from the current state and the decode inputs. State, load-stall counter and SplitCount are registered on posedge clk.
- Reset (synchronous, active-high):
  - state = PAIR, load counter = 0, SplitCount = 0.
  - While rst = 1: StallF = StallD = FlushE1 = FlushE2 = 0.
- Hazard definitions:
  - Zero register: a destination of 0 never creates a hazard.
  - LU (load-use): (MemReadE1 and RdE1 != 0 and RdE1 matches any valid decode source) or the same condition for E2.
  - DEP (data): ValidD1 and ValidD2 and RegWriteD1 and RdD1 != 0 and (RdD1 == Rs1D2 or RdD1 == Rs2D2 or (CHECK_WAW and RegWriteD2 and RdD1 == RdD2)).
  - CTL (control): ValidD1 and ValidD2 and BranchD1.
- State PAIR:
  - If LU: StallF = StallD = FlushE1 = FlushE2 = 1. Load counter <= LOAD_STALL-1. If LOAD_STALL > 1, next state LOAD_WAIT; otherwise stay in PAIR.
  - Else if DEP or CTL: StallF = StallD = 1, FlushE2 = 1 (slot 1 issues alone). Next state SPLIT. SplitCount increments unless at all-ones.
  - Else: all outputs 0 (normal dual issue).
- State LOAD_WAIT:
  - StallF = StallD = FlushE1 = FlushE2 = 1. Counter decrements.
  - When the counter reaches 0, next state PAIR; hazards are re-evaluated there.
- State SPLIT:
  - FlushE1 = 1, because slot 1 already issued and must not re-issue. StallF = StallD = 0, so slot 2 issues alone into E2.
  - LU against slot 2 sources only: stall as in PAIR and remain in SPLIT.
  - Otherwise next state PAIR.
- FlushIn: highest priority in every state. All of this unit's outputs are 0, next state is PAIR, and the load counter is cleared. SplitCount is not changed.
- ValidD2 = 0: DEP/CTL cannot fire, so a single instruction never splits.
- rst asserted in any state returns to PAIR on the next edge; no partial split survives.
- SplitCount saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Independent pair (add x5 / add x6, disjoint sources) → all stall/flush 0, state PAIR, SplitCount 0.
- RAW pair (RdD1 = 5, Rs1D2 = 5, RegWriteD1 = 1) → cycle N: StallF = StallD = FlushE2 = 1. Cycle N+1: FlushE1 = 1 only. Cycle N+2: all 0. SplitCount = 1.
- WAW pair (RdD1 = RdD2 = 7, no RAW): with CHECK_WAW = 1 → split as above; with CHECK_WAW = 0 → no stall. Pair with RdD1 = 0 and Rs1D2 = 0 → no split.
- Load-use (MemReadE2 = 1, RdE2 = 9, Rs2D1 = 9) with LOAD_STALL = 3 → full stall plus both flushes for exactly 3 cycles, then PAIR.
- BranchD1 = 1 with ValidD2 = 1 → split. FlushIn asserted during the SPLIT cycle → all outputs 0, next state PAIR.
- Force SplitCount to all-ones via repeated splits with CNT_W = 2 → holds at 3. rst mid-LOAD_WAIT → outputs 0 next cycle, counter 0.
